// File: rtl/aq_ifu_ipack_buf_pkg.sv
// Shared IFU instruction-package types: instruction width, default buffer depth
// and the per-entry field layout.
package aq_ifu_ipack_buf_pkg;

    localparam int unsigned IPACK_INST_W    = 32;
    localparam int unsigned IPACK_BUF_DEPTH = 4;

    typedef struct packed {
        logic [IPACK_INST_W-1:0] inst;
        logic                    acc_err;
        logic                    pgflt;
    } ipack_entry_t;

endpackage

// File: rtl/aq_ifu_ipack_buf_slot.sv
// One instruction-buffer entry: instruction plus fault tags, written when
// selected by the top-level create decode.
module aq_ifu_ipack_buf_slot
    import aq_ifu_ipack_buf_pkg::*;
(
    input  logic         forever_cpuclk,
    input  logic         cpurst,
    input  logic         wr_en_i,
    input  ipack_entry_t wr_data_i,
    output ipack_entry_t entry_o
);

    ipack_entry_t entry_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            entry_q <= '0;
        end else if (wr_en_i) begin
            entry_q <= wr_data_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/aq_ifu_ipack_buf.sv
// Instruction package buffer: circular FIFO taking up to two packed instructions
// per cycle from IFU and issuing one per cycle to decode.
module aq_ifu_ipack_buf
    import aq_ifu_ipack_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = IPACK_BUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    ipack_buf_flush,
    input  logic                    ifu_ipack_inst0_vld,
    input  logic [IPACK_INST_W-1:0] ifu_ipack_inst0,
    input  logic                    ifu_ipack_acc_err0,
    input  logic                    ifu_ipack_pgflt0,
    input  logic                    ifu_ipack_inst1_vld,
    input  logic [IPACK_INST_W-1:0] ifu_ipack_inst1,
    input  logic                    ifu_ipack_acc_err1,
    input  logic                    ifu_ipack_pgflt1,
    output logic                    ipack_ifu_ready,
    output logic                    ipack_id_inst_vld,
    output logic [IPACK_INST_W-1:0] ipack_id_inst,
    output logic                    ipack_id_acc_err,
    output logic                    ipack_id_pgflt,
    input  logic                    id_ipack_inst_rdy,
    output logic [PTR_W:0]          ipack_buf_entry_cnt
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d, wptr_p1;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready, crt0, crt1, ret;

    ipack_entry_t     slot0_data, slot1_data, head;
    ipack_entry_t     entry_q [DEPTH];
    ipack_entry_t     wr_data [DEPTH];
    logic [DEPTH-1:0] wr_en;

    // Room for a full dual create, judged from registered occupancy only
    assign ready = (cnt_q <= CNT_W'(DEPTH - 2));
    assign crt0  = ifu_ipack_inst0_vld && ready;
    assign crt1  = ifu_ipack_inst1_vld && ready;
    assign ret   = ipack_id_inst_vld && id_ipack_inst_rdy;

    assign wptr_p1    = wptr_q + PTR_W'(1);
    assign slot0_data = '{inst: ifu_ipack_inst0, acc_err: ifu_ipack_acc_err0, pgflt: ifu_ipack_pgflt0};
    assign slot1_data = '{inst: ifu_ipack_inst1, acc_err: ifu_ipack_acc_err1, pgflt: ifu_ipack_pgflt1};

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (ipack_buf_flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            wptr_d = wptr_q + PTR_W'(crt0) + PTR_W'(crt1);
            rptr_d = rptr_q + PTR_W'(ret);
            cnt_d  = cnt_q + CNT_W'(crt0) + CNT_W'(crt1) - CNT_W'(ret);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Slot0 lands at wptr, slot1 at wptr+1; nothing is written in a flush cycle
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic hit0, hit1;
        assign hit0       = crt0 && (wptr_q == PTR_W'(i));
        assign hit1       = crt1 && (wptr_p1 == PTR_W'(i));
        assign wr_en[i]   = !ipack_buf_flush && (hit0 || hit1);
        assign wr_data[i] = hit0 ? slot0_data : slot1_data;

        aq_ifu_ipack_buf_slot u_slot (
            .forever_cpuclk (forever_cpuclk),
            .cpurst         (cpurst),
            .wr_en_i        (wr_en[i]),
            .wr_data_i      (wr_data[i]),
            .entry_o        (entry_q[i])
        );
    end

    assign head                = entry_q[rptr_q];
    assign ipack_ifu_ready     = ready;
    assign ipack_id_inst_vld   = (cnt_q != '0);
    assign ipack_id_inst       = head.inst;
    assign ipack_id_acc_err    = head.acc_err;
    assign ipack_id_pgflt      = head.pgflt;
    assign ipack_buf_entry_cnt = cnt_q;

    ill_slot1_a: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        !(ifu_ipack_inst1_vld && !ifu_ipack_inst0_vld));

endmodule

// File: tb/tb_aq_ifu_ipack_buf.sv
// Scoreboard bench for aq_ifu_ipack_buf: expected entries queued on accepted
// creates, popped and compared by a negedge monitor on every retire.
module tb_aq_ifu_ipack_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    typedef struct {
        logic [31:0] inst;
        logic        ae;
        logic        pf;
    } exp_t;

    logic             clk = 1'b0;
    logic             cpurst = 1'b1;
    logic             flush = 1'b0;
    logic             v0 = 1'b0, v1 = 1'b0;
    logic [31:0]      i0 = '0, i1 = '0;
    logic             ae0 = 1'b0, pf0 = 1'b0, ae1 = 1'b0, pf1 = 1'b0;
    logic             rdy = 1'b0;
    logic             ready, vld, acc_err, pgflt;
    logic [31:0]      inst;
    logic [PTR_W:0]   cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    aq_ifu_ipack_buf #(.DEPTH(DEPTH)) dut (
        .forever_cpuclk      (clk),
        .cpurst              (cpurst),
        .ipack_buf_flush     (flush),
        .ifu_ipack_inst0_vld (v0),
        .ifu_ipack_inst0     (i0),
        .ifu_ipack_acc_err0  (ae0),
        .ifu_ipack_pgflt0    (pf0),
        .ifu_ipack_inst1_vld (v1),
        .ifu_ipack_inst1     (i1),
        .ifu_ipack_acc_err1  (ae1),
        .ifu_ipack_pgflt1    (pf1),
        .ipack_ifu_ready     (ready),
        .ipack_id_inst_vld   (vld),
        .ipack_id_inst       (inst),
        .ipack_id_acc_err    (acc_err),
        .ipack_id_pgflt      (pgflt),
        .id_ipack_inst_rdy   (rdy),
        .ipack_buf_entry_cnt (cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] in, input logic ae, input logic pf);
        exp_t e;
        e.inst = in;
        e.ae   = ae;
        e.pf   = pf;
        return e;
    endfunction

    // Monitor: occupancy, ready and head contents against the scoreboard queue
    always @(negedge clk) begin
        if (!cpurst) begin
            chk("cnt", 32'(cnt), 32'(exp_q.size()));
            chk("ready", 32'(ready), 32'(exp_q.size() <= DEPTH - 2));
            chk("vld", 32'(vld), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("head_inst", inst, exp_q[0].inst);
                chk("head_acc_err", 32'(acc_err), 32'(exp_q[0].ae));
                chk("head_pgflt", 32'(pgflt), 32'(exp_q[0].pf));
                if (rdy && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; model effects applied just after the edge
    task automatic step(input logic fl, input logic c0, input exp_t e0,
                        input logic c1, input exp_t e1, input logic r);
        bit acc;
        flush = fl; rdy = r;
        v0 = c0; i0 = e0.inst; ae0 = e0.ae; pf0 = e0.pf;
        v1 = c1; i1 = e1.inst; ae1 = e1.ae; pf1 = e1.pf;
        acc = (exp_q.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            if (c0) exp_q.push_back(e0);
            if (c1) exp_q.push_back(e1);
        end
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, mk(0, 0, 0), 1'b0, mk(0, 0, 0), r);
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        flush = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cpurst = 1'b0;
        exp_q.delete();
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_acc_err", 32'(acc_err), 32'd0);
        chk("rst_pgflt", 32'(pgflt), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_cnt", 32'(cnt), 32'd0);
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 0);
        do_reset();

        // Dual create into empty, then drain
        step(0, 1, mk(32'h0000_0013, 0, 0), 1, mk(32'h0040_0093, 0, 0), 0);
        idle(1); idle(1); idle(0);

        // Fill to DEPTH, dropped request, then retire back to ready
        step(0, 1, mk(32'h1111_0001, 0, 0), 1, mk(32'h1111_0002, 0, 0), 0);
        step(0, 1, mk(32'h1111_0003, 0, 0), 1, mk(32'h1111_0004, 0, 0), 0);
        step(0, 1, mk(32'hDEAD_0005, 0, 0), 1, mk(32'hDEAD_0006, 0, 0), 0);
        chk("full_cnt", 32'(cnt), 32'd4);
        chk("full_ready", 32'(ready), 32'd0);
        idle(1);
        chk("cnt3_ready", 32'(ready), 32'd0);
        idle(1);
        chk("cnt2_ready", 32'(ready), 32'd1);
        idle(1); idle(1); idle(0);

        // Walk pointers to rptr=3/wptr=0, then single create with retire
        step(1, 0, z, 0, z, 0);
        step(0, 1, mk(32'h2222_0000, 0, 0), 1, mk(32'h2222_0001, 0, 0), 0);
        step(0, 1, mk(32'h2222_0002, 0, 0), 0, z, 0);
        step(0, 1, mk(32'h2222_0003, 0, 0), 0, z, 1);
        idle(1); idle(1);
        step(0, 1, mk(32'h2222_0004, 0, 0), 0, z, 1);
        chk("wrap_cnt", 32'(cnt), 32'd1);
        chk("wrap_head", inst, 32'h2222_0004);

        // Randomised create/retire/flush traffic
        for (int n = 0; n < 200; n++) begin
            logic c0, c1, fl;
            c0 = 1'($urandom_range(0, 1));
            c1 = c0 & 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            step(fl, c0, mk($urandom, 1'($urandom), 1'($urandom)),
                 c1, mk($urandom, 1'($urandom), 1'($urandom)), 1'($urandom_range(0, 1)));
        end

        // Flush with simultaneous dual create and retire at cnt=3
        step(1, 0, z, 0, z, 0);
        step(0, 1, mk(32'h3333_0000, 0, 0), 1, mk(32'h3333_0001, 0, 0), 0);
        step(0, 1, mk(32'h3333_0002, 0, 0), 0, z, 0);
        chk("pre_flush_cnt", 32'(cnt), 32'd3);
        step(1, 1, mk(32'hBAD0_0000, 0, 0), 1, mk(32'hBAD0_0001, 0, 0), 1);
        chk("flush_cnt", 32'(cnt), 32'd0);
        chk("flush_vld", 32'(vld), 32'd0);
        chk("flush_ready", 32'(ready), 32'd1);
        step(0, 1, mk(32'h4444_0000, 0, 0), 0, z, 0);
        chk("post_flush_head", inst, 32'h4444_0000);
        idle(1);

        // Fault tags follow their own entries
        step(0, 1, mk(32'h5555_0000, 0, 1), 1, mk(32'h5555_0001, 1, 0), 0);
        chk("tag0_pgflt", 32'(pgflt), 32'd1);
        chk("tag0_acc_err", 32'(acc_err), 32'd0);
        idle(1);
        chk("tag1_pgflt", 32'(pgflt), 32'd0);
        chk("tag1_acc_err", 32'(acc_err), 32'd1);
        idle(1); idle(0);

        // Reset mid-operation discards contents
        step(0, 1, mk(32'h6666_0000, 1, 1), 1, mk(32'h6666_0001, 1, 1), 0);
        do_reset();
        idle(0); idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
